// File: rtl/ifu_fetch_stage.sv
// Instruction fetch stage: holds the PC, issues one read at a time on an
// AR/R memory channel and presents {pc, inst} to decode over valid/ready.
// A flush from execute redirects the PC and discards any stale response.
// Optional feature macro: IFU_FAULT_EN adds out_fault for misaligned PCs
// and non-OKAY read responses.
module ifu_fetch_stage #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h3000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic [PC_W-1:0] dnpc,
  output logic [PC_W-1:0] mem_araddr,
  output logic            mem_arvalid,
  input  logic            mem_arready,
  input  logic [31:0]     mem_rdata,
  input  logic [1:0]      mem_rresp,
  input  logic            mem_rvalid,
  output logic            mem_rready,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_inst
`ifdef IFU_FAULT_EN
  ,output logic           out_fault
`endif
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [31:0]     inst, inst_nxt;
  logic            ar_fire;

`ifdef IFU_FAULT_EN
  logic            fault, fault_nxt;
  logic            misaligned;
  assign misaligned = (pc[1:0] != 2'b00);
  // A misaligned PC never reaches the bus; it is turned into a fault instead
  assign mem_arvalid = (state == ST_REQ) & reset & ~misaligned;
  assign out_fault   = fault;
`else
  logic            unused_rresp;
  assign unused_rresp = ^mem_rresp;
  assign mem_arvalid  = (state == ST_REQ) & reset;
`endif

  assign mem_rready = (state == ST_WAIT) | (state == ST_DRAIN);
  assign out_valid  = (state == ST_HOLD) & ~flush;
  assign mem_araddr = pc;
  assign out_pc     = pc;
  assign out_inst   = inst;
  assign ar_fire    = mem_arvalid & mem_arready;

  // Next-state logic: flush always redirects the PC; responses that belong to a
  // redirected fetch are consumed but never captured
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst;
`ifdef IFU_FAULT_EN
    fault_nxt = fault;
`endif
    case (state)
      ST_REQ: begin
`ifdef IFU_FAULT_EN
        if (misaligned & ~flush) begin
          state_nxt = ST_HOLD;
          inst_nxt  = 32'h0;
          fault_nxt = 1'b1;
        end else
`endif
        begin
          if (ar_fire) begin
            if (flush) begin
              pc_nxt    = dnpc;
              state_nxt = ST_DRAIN;
            end else begin
              state_nxt = ST_WAIT;
            end
          end else if (flush) begin
            pc_nxt = dnpc;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          pc_nxt    = dnpc;
          state_nxt = mem_rvalid ? ST_REQ : ST_DRAIN;
        end else if (mem_rvalid) begin
          inst_nxt  = mem_rdata;
          state_nxt = ST_HOLD;
`ifdef IFU_FAULT_EN
          fault_nxt = (mem_rresp != 2'b00);
`endif
        end
      end
      ST_DRAIN: begin
        if (flush) begin
          pc_nxt = dnpc;
        end
        if (mem_rvalid) begin
          state_nxt = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          pc_nxt    = dnpc;
          state_nxt = ST_REQ;
        end else if (out_ready) begin
          pc_nxt    = pc + PC_W'(4);
          state_nxt = ST_REQ;
        end
      end
      default: begin
        state_nxt = ST_REQ;
      end
    endcase
`ifdef IFU_FAULT_EN
    if (flush && (state_nxt == ST_REQ)) begin
      fault_nxt = 1'b0;
    end
`endif
  end

  // State, PC and instruction registers; reset takes effect immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_REQ;
      pc    <= RESET_PC;
      inst  <= 32'h0;
`ifdef IFU_FAULT_EN
      fault <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      inst  <= inst_nxt;
`ifdef IFU_FAULT_EN
      fault <= fault_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Bench for ifu_fetch_stage: a memory model answers each read with a word
// derived from its address, and a scoreboard holds the next instruction the
// architectural PC says decode must receive.
module tb_ifu_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] dnpc;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid;
  logic        mem_rready;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef IFU_FAULT_EN
  logic        out_fault;
`endif

  ifu_fetch_stage #(.PC_W(32), .RESET_PC(RESET_PC)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .dnpc        (dnpc),
    .mem_araddr  (mem_araddr),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst)
`ifdef IFU_FAULT_EN
    ,.out_fault  (out_fault)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b1;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_pc, hold_inst;
  int          stall = 0;

  bit          ar_seen = 1'b0;
  bit          r_seen = 1'b0;
  logic [31:0] ar_seen_addr = 32'h0;
  bit          mem_pend = 1'b0;
  int          mem_delay = 0;
  logic [31:0] mem_addr = 32'h0;
  int          fixed_delay = -1;
  bit          mem_override = 1'b0;
  logic [1:0]  mem_force_resp = 2'b00;

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory contents: a bijection of the address, so a stale word never
  // matches the word expected at a redirected PC
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr - RESET_PC) * 32'h9E37_79B1 + 32'h0000_0413;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory side: accepts a read seen at the previous negedge and answers after
  // a delay, holding rvalid until the beat is consumed
  task automatic memStep();
    if (r_seen) begin
      mem_rvalid = 1'b0;
      mem_pend   = 1'b0;
    end
    if (ar_seen) begin
      mem_pend  = 1'b1;
      mem_addr  = ar_seen_addr;
      mem_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
    end
    if (mem_pend && !mem_rvalid) begin
      if (mem_delay == 0) begin
        mem_rvalid = 1'b1;
        mem_rresp  = mem_force_resp;
        if (mem_override) begin
          mem_rdata    = 32'hDEAD_BEEF;
          mem_override = 1'b0;
        end else begin
          mem_rdata = memWord(mem_addr);
        end
      end else begin
        mem_delay--;
      end
    end
  endtask

  task automatic memReset();
    mem_pend   = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    mem_rresp  = 2'b00;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    memStep();
  endtask

  task automatic applyStimulus();
    mem_arready = ($urandom_range(0, 3) != 0);
    out_ready   = ($urandom_range(0, 9) < 7);
    flush       = ($urandom_range(0, 11) == 0);
    dnpc        = $urandom & 32'hFFFF_FFFC;
    step();
  endtask

  // Monitor and scoreboard: sample mid-cycle, compare every decode handshake
  // against the architectural PC and its memory word, and track the PC model
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      exp_q.push_back('{RESET_PC, memWord(RESET_PC)});
      ar_seen   = 1'b0;
      r_seen    = 1'b0;
      hold_prev = 1'b0;
      stall     = 0;
    end else begin
      ar_seen      = mem_arvalid && mem_arready;
      ar_seen_addr = mem_araddr;
      r_seen       = mem_rvalid && mem_rready;
      if (mon_en) begin
        if (mem_arvalid && (mem_pend || mem_rvalid))
          checkOutput("single_outstanding", 32'(mem_arvalid), 32'h0);
        if (ar_seen)
          checkOutput("ar_addr", mem_araddr, exp_q[0].pc);
        if (flush)
          checkOutput("flush_out_valid", 32'(out_valid), 32'h0);
        if (hold_prev && !flush) begin
          checkOutput("hold_valid", 32'(out_valid), 32'h1);
          checkOutput("hold_pc", out_pc, hold_pc);
          checkOutput("hold_inst", out_inst, hold_inst);
        end
        if (out_valid && out_ready) begin
          exp_t head;
          head = exp_q.pop_front();
          checkOutput("out_pc", out_pc, head.pc);
          checkOutput("out_inst", out_inst, head.inst);
`ifdef IFU_FAULT_EN
          checkOutput("out_fault_clear", 32'(out_fault), 32'h0);
`endif
          exp_q.push_back('{head.pc + 32'd4, memWord(head.pc + 32'd4)});
          stall = 0;
        end else begin
          stall++;
        end
        if (flush) begin
          exp_q.delete();
          exp_q.push_back('{dnpc, memWord(dnpc)});
        end
        hold_prev = out_valid && !out_ready && !flush;
        hold_pc   = out_pc;
        hold_inst = out_inst;
        if (stall > 300) begin
          checkOutput("progress_timeout", 32'(stall), 32'd300);
          stall = 0;
        end
      end else begin
        hold_prev = 1'b0;
        stall     = 0;
      end
    end
  end

  // Absolute time bound so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios first, then a randomized run
  initial begin
    bit found;
    reset       = 1'b0;
    flush       = 1'b0;
    dnpc        = 32'h0;
    mem_arready = 1'b0;
    out_ready   = 1'b0;
    memReset();
    repeat (3) step();

    checkOutput("rst_arvalid", 32'(mem_arvalid), 32'h0);
    checkOutput("rst_rready", 32'(mem_rready), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_araddr", mem_araddr, RESET_PC);
    checkOutput("rst_out_pc", out_pc, RESET_PC);
    checkOutput("rst_out_inst", out_inst, 32'h0);

    // Best-case fetch right after reset release
    reset       = 1'b1;
    mem_arready = 1'b1;
    out_ready   = 1'b1;
    fixed_delay = 0;
    #1;
    checkOutput("first_arvalid", 32'(mem_arvalid), 32'h1);
    checkOutput("first_araddr", mem_araddr, RESET_PC);
    step();
    checkOutput("lat1_out_valid", 32'(out_valid), 32'h0);
    step();
    checkOutput("lat2_out_valid", 32'(out_valid), 32'h1);
    checkOutput("lat2_out_pc", out_pc, RESET_PC);
    checkOutput("lat2_out_inst", out_inst, 32'h0000_0413);
    step();
    checkOutput("next_arvalid", 32'(mem_arvalid), 32'h1);
    checkOutput("next_araddr", mem_araddr, RESET_PC + 32'd4);

    // Flush while waiting for a slow response carrying 0xDEADBEEF
    fixed_delay  = 3;
    mem_override = 1'b1;
    step();
    flush = 1'b1;
    dnpc  = 32'h8000_0010;
    step();
    flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_arvalid && mem_arready) found = 1'b1;
    end
    checkOutput("redirect_ar_seen", 32'(found), 32'h1);
    checkOutput("redirect_araddr", mem_araddr, 32'h8000_0010);

    // Asynchronous reset while a read is outstanding
    step();
    reset = 1'b0;
    #1;
    memReset();
    checkOutput("midrst_arvalid", 32'(mem_arvalid), 32'h0);
    checkOutput("midrst_rready", 32'(mem_rready), 32'h0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("midrst_out_pc", out_pc, RESET_PC);
    repeat (2) step();
    reset       = 1'b1;
    fixed_delay = 0;
    out_ready   = 1'b0;
    #1;
    checkOutput("relrst_arvalid", 32'(mem_arvalid), 32'h1);
    checkOutput("relrst_araddr", mem_araddr, RESET_PC);

    // Back-pressure from decode holds the instruction and blocks new reads
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("bp_out_valid", 32'(out_valid), 32'h1);
      checkOutput("bp_arvalid", 32'(mem_arvalid), 32'h0);
      checkOutput("bp_out_inst", out_inst, 32'h0000_0413);
    end
    out_ready = 1'b1;
    step();
    checkOutput("bp_next_araddr", mem_araddr, RESET_PC + 32'd4);
    checkOutput("bp_next_arvalid", 32'(mem_arvalid), 32'h1);

    // Randomized traffic against the scoreboard
    fixed_delay = -1;
    for (int i = 0; i < 3000; i++) applyStimulus();
    flush = 1'b0;
    repeat (10) step();

`ifdef IFU_FAULT_EN
    // Misaligned redirect and error response both raise out_fault
    mon_en      = 1'b0;
    reset       = 1'b0;
    #1;
    memReset();
    mem_arready = 1'b0;
    out_ready   = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    flush = 1'b1;
    dnpc  = 32'h3000_0002;
    step();
    flush = 1'b0;
    checkOutput("mis_arvalid", 32'(mem_arvalid), 32'h0);
    step();
    checkOutput("mis_out_valid", 32'(out_valid), 32'h1);
    checkOutput("mis_out_fault", 32'(out_fault), 32'h1);
    checkOutput("mis_out_inst", out_inst, 32'h0);
    checkOutput("mis_out_pc", out_pc, 32'h3000_0002);
    flush = 1'b1;
    dnpc  = 32'h3000_0100;
    step();
    flush          = 1'b0;
    mem_arready    = 1'b1;
    fixed_delay    = 0;
    mem_force_resp = 2'd2;
    repeat (2) step();
    checkOutput("err_out_valid", 32'(out_valid), 32'h1);
    checkOutput("err_out_fault", 32'(out_fault), 32'h1);
    checkOutput("err_out_inst", out_inst, memWord(32'h3000_0100));
    mem_force_resp = 2'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
